// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares one fixed-latency single-port DM between the
// pipeline M stage (CPU) and the debug/boot loader (DBG) with round-robin ties.
module dm_arbiter #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [29:0]       adr_q, adr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;
  logic              dbg_gnt_c;
  logic              pick_dbg;

  // Byte-lane bits never reach the word-addressed memory.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{cpu_adr[1:0], dbg_adr[1:0]};

  // Next-state, latch and read-capture logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_gnt_c   = 1'b0;
    pick_dbg    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          // On a tie the port that did not win last time goes first.
          pick_dbg  = dbg_req && (!cpu_req || (last_q == OWN_CPU));
          dbg_gnt_c = pick_dbg;
          owner_d   = pick_dbg ? OWN_DBG : OWN_CPU;
          last_d    = pick_dbg ? OWN_DBG : OWN_CPU;
          we_d      = pick_dbg ? dbg_we : cpu_we;
          adr_d     = pick_dbg ? dbg_adr[31:2] : cpu_adr[31:2];
          wdata_d   = pick_dbg ? dbg_wdata : cpu_wdata;
          cnt_d     = CNT_LOAD;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!we_q) begin
            if (owner_q == OWN_DBG) dbg_rdata_d = mem_rdata;
            else                    cpu_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_DBG;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Strobes decode straight from the state flop so reset drops them at once.
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = (state_q == S_ACCESS) && we_q;
  assign mem_adr   = {adr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign dbg_gnt   = dbg_gnt_c;
  assign dbg_done  = (state_q == S_DONE) && (owner_q == OWN_DBG);
  assign cpu_stall = cpu_req && !((state_q == S_DONE) && (owner_q == OWN_CPU));
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: LATENCY=2 main instance plus a LATENCY=1 build.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_adr, cpu_wdata, dbg_adr, dbg_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_adr, mem_wdata;
  logic        cpu_stall, dbg_gnt, dbg_done, mem_en, mem_we;

  logic        cpu_req1;
  logic [31:0] mem_rdata1;
  logic [31:0] cpu_rdata1, dbg_rdata1, mem_adr1, mem_wdata1;
  logic        cpu_stall1, dbg_gnt1, dbg_done1, mem_en1, mem_we1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.LATENCY(2), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dm_arbiter #(.LATENCY(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req1), .cpu_we(1'b0), .cpu_adr(32'h0000_0100), .cpu_wdata(32'h0),
    .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_adr(32'h0), .dbg_wdata(32'h0),
    .dbg_gnt(dbg_gnt1), .dbg_done(dbg_done1), .dbg_rdata(dbg_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_adr(mem_adr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = '0; dbg_wdata = '0;
    mem_rdata = '0; cpu_req1 = 1'b0; mem_rdata1 = '0;

    // Reset held three cycles with cpu_req high.
    repeat (3) tick();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h1);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_gnt", 32'(dbg_gnt), 32'h0);
    chk("rst_done", 32'(dbg_done), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    cpu_req = 1'b0; reset = 1'b1; #1;
    chk("rel_stall", 32'(cpu_stall), 32'h0);
    tick();
    chk("rel_idle_en", 32'(mem_en), 32'h0);

    // CPU load to an unaligned byte address.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0000_1006; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("ld_c0_stall", 32'(cpu_stall), 32'h1);
    chk("ld_c0_en", 32'(mem_en), 32'h0);
    tick();
    chk("ld_c1_en", 32'(mem_en), 32'h1);
    chk("ld_c1_we", 32'(mem_we), 32'h0);
    chk("ld_c1_adr", mem_adr, 32'h0000_1004);
    chk("ld_c1_stall", 32'(cpu_stall), 32'h1);
    tick();
    chk("ld_c2_en", 32'(mem_en), 32'h1);
    chk("ld_c2_stall", 32'(cpu_stall), 32'h1);
    tick();
    chk("ld_done_en", 32'(mem_en), 32'h0);
    chk("ld_done_stall", 32'(cpu_stall), 32'h0);
    chk("ld_done_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("ld_done_dbgdone", 32'(dbg_done), 32'h0);
    cpu_req = 1'b0;
    tick();
    chk("ld_idle_en", 32'(mem_en), 32'h0);
    chk("ld_hold_rdata", cpu_rdata, 32'hDEAD_BEEF);

    // CPU store: read data must not be captured.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h20; cpu_wdata = 32'h1234_5678;
    mem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("st_c1_we", 32'(mem_we), 32'h1);
    chk("st_c1_wdata", mem_wdata, 32'h1234_5678);
    chk("st_c1_adr", mem_adr, 32'h20);
    tick();
    chk("st_c2_we", 32'(mem_we), 32'h1);
    chk("st_c2_en", 32'(mem_en), 32'h1);
    tick();
    chk("st_done_en", 32'(mem_en), 32'h0);
    chk("st_done_stall", 32'(cpu_stall), 32'h0);
    chk("st_done_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("st_done_dbgdone", 32'(dbg_done), 32'h0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();

    // Fresh reset, then both ports request and hold: CPU, DBG, CPU.
    reset = 1'b0; #1; reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h8; mem_rdata = 32'h1111_1111;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 32'h40; dbg_wdata = 32'hCAFE_F00D; #1;
    chk("rr_c0_gnt", 32'(dbg_gnt), 32'h0);
    chk("rr_c0_stall", 32'(cpu_stall), 32'h1);
    tick();
    chk("rr_a1_adr", mem_adr, 32'h8);
    chk("rr_a1_we", 32'(mem_we), 32'h0);
    tick();
    tick();
    chk("rr_cdone_stall", 32'(cpu_stall), 32'h0);
    chk("rr_cdone_rdata", cpu_rdata, 32'h1111_1111);
    chk("rr_cdone_gnt", 32'(dbg_gnt), 32'h0);
    tick();
    chk("rr_dgnt", 32'(dbg_gnt), 32'h1);
    chk("rr_dgnt_stall", 32'(cpu_stall), 32'h1);
    tick();
    dbg_adr = 32'hFFFF_FFFC; dbg_wdata = 32'h0; dbg_we = 1'b0; #1;
    chk("rr_d1_gnt", 32'(dbg_gnt), 32'h0);
    chk("rr_d1_we", 32'(mem_we), 32'h1);
    chk("rr_d1_adr", mem_adr, 32'h40);
    chk("rr_d1_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("rr_d1_stall", 32'(cpu_stall), 32'h1);
    tick();
    chk("rr_d2_done", 32'(dbg_done), 32'h0);
    chk("rr_d2_stall", 32'(cpu_stall), 32'h1);
    tick();
    chk("rr_ddone", 32'(dbg_done), 32'h1);
    chk("rr_ddone_stall", 32'(cpu_stall), 32'h1);
    chk("rr_ddone_en", 32'(mem_en), 32'h0);
    dbg_req = 1'b0; mem_rdata = 32'h2222_2222;
    tick();
    chk("rr_c2_gnt", 32'(dbg_gnt), 32'h0);
    chk("rr_c2_done", 32'(dbg_done), 32'h0);
    tick();
    chk("rr_c2_adr", mem_adr, 32'h8);
    tick();
    tick();
    chk("rr_c2done_stall", 32'(cpu_stall), 32'h0);
    chk("rr_c2done_rdata", cpu_rdata, 32'h2222_2222);
    cpu_req = 1'b0;
    tick();

    // DBG load alone: CPU not requesting must never stall.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h100; mem_rdata = 32'h5A5A_5A5A; #1;
    chk("dl_gnt", 32'(dbg_gnt), 32'h1);
    tick();
    dbg_req = 1'b0; #1;
    chk("dl_a1_stall", 32'(cpu_stall), 32'h0);
    chk("dl_a1_adr", mem_adr, 32'h100);
    tick();
    tick();
    chk("dl_done", 32'(dbg_done), 32'h1);
    chk("dl_rdata", dbg_rdata, 32'h5A5A_5A5A);
    chk("dl_cpu_rdata", cpu_rdata, 32'h2222_2222);
    tick();
    chk("dl_idle_done", 32'(dbg_done), 32'h0);

    // Reset during the first ACCESS cycle of a DBG write.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 32'h80; dbg_wdata = 32'h7777_7777; #1;
    chk("rm_gnt", 32'(dbg_gnt), 32'h1);
    tick();
    chk("rm_a1_en", 32'(mem_en), 32'h1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h30; reset = 1'b0; #1;
    chk("rm_async_en", 32'(mem_en), 32'h0);
    chk("rm_async_we", 32'(mem_we), 32'h0);
    tick();
    chk("rm_hold_done", 32'(dbg_done), 32'h0);
    reset = 1'b1; #1;
    chk("rm_rel_gnt", 32'(dbg_gnt), 32'h0);
    chk("rm_rel_stall", 32'(cpu_stall), 32'h1);
    tick();
    dbg_req = 1'b0; #1;
    chk("rm_cpu_adr", mem_adr, 32'h30);
    chk("rm_cpu_we", 32'(mem_we), 32'h0);
    chk("rm_no_done", 32'(dbg_done), 32'h0);
    tick();
    tick();
    chk("rm_cpu_done_stall", 32'(cpu_stall), 32'h0);
    cpu_req = 1'b0;
    tick();

    // LATENCY=1 build: back-to-back CPU loads, three cycles each.
    cpu_req1 = 1'b1; mem_rdata1 = 32'h0000_00A1; #1;
    chk("l1_g1_stall", 32'(cpu_stall1), 32'h1);
    chk("l1_g1_en", 32'(mem_en1), 32'h0);
    tick();
    chk("l1_a1_en", 32'(mem_en1), 32'h1);
    chk("l1_a1_stall", 32'(cpu_stall1), 32'h1);
    tick();
    chk("l1_d1_en", 32'(mem_en1), 32'h0);
    chk("l1_d1_stall", 32'(cpu_stall1), 32'h0);
    chk("l1_d1_rdata", cpu_rdata1, 32'h0000_00A1);
    mem_rdata1 = 32'h0000_00B2;
    tick();
    chk("l1_g2_en", 32'(mem_en1), 32'h0);
    chk("l1_g2_stall", 32'(cpu_stall1), 32'h1);
    tick();
    chk("l1_a2_en", 32'(mem_en1), 32'h1);
    tick();
    chk("l1_d2_en", 32'(mem_en1), 32'h0);
    chk("l1_d2_stall", 32'(cpu_stall1), 32'h0);
    chk("l1_d2_rdata", cpu_rdata1, 32'h0000_00B2);
    cpu_req1 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
